// File: rtl/gpr_wport_arbiter.sv
// Arbitrates the single GPR write port between WB (zero added latency) and buffered LU results.
// LU entries wait in a small FIFO; a starvation counter eventually holds WB so the FIFO drains.
module gpr_wport_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        iss_valid,
  input  logic        iss_long,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        hazard,
  output logic        gpr_we,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  LIMIT_C = 4'(STARVE_LIMIT);

  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    starve_cnt, starve_nxt;
  logic [31:0]   busy, busy_nxt;

  logic empty, full, wb_req, force_fifo, grant_wb, grant_fifo, push, pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // rd 0 is never a real write, so it neither requests the port nor gets buffered
  assign wb_req     = wb_valid && (wb_rd != 5'd0);
  assign force_fifo = (starve_cnt == LIMIT_C) && !empty;
  assign grant_fifo = force_fifo || (!wb_req && !empty);
  assign grant_wb   = !force_fifo && wb_req;

  assign wb_ready  = !(force_fifo && wb_req);
  assign lu_ready  = !full;
  assign push      = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop       = grant_fifo;

  assign gpr_we    = !rst && (grant_wb || grant_fifo);
  assign gpr_waddr = grant_fifo ? head_rd   : wb_rd;
  assign gpr_wdata = grant_fifo ? head_data : wb_data;

  assign hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lu_rd;
      fifo_data[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || pop)
      starve_nxt = 4'd0;
    else if (grant_wb && (starve_cnt != LIMIT_C))
      starve_nxt = starve_cnt + 4'd1;
  end

  // A new long issue to the same rd as the retiring write must stay busy, so set follows clear
  always_comb begin
    busy_nxt = busy;
    if (pop)
      busy_nxt[head_rd] = 1'b0;
    if (iss_valid && iss_long && (iss_rd != 5'd0))
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      busy       <= 32'd0;
    end else begin
      starve_cnt <= starve_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Directed bench for gpr_wport_arbiter: WB path, LU buffering, starvation, full FIFO, scoreboard, async reset.
module tb_gpr_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, lu_valid, iss_valid, iss_long;
  logic [4:0]  wb_rd, lu_rd, iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic [31:0] wb_data, lu_data;
  logic        wb_ready, lu_ready, hazard, gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  int n_cmp = 0;
  int n_err = 0;

  gpr_wport_arbiter #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check({tag, ".we"},    32'(gpr_we), 32'd1);
    check({tag, ".waddr"}, 32'(gpr_waddr), 32'(addr));
    check({tag, ".wdata"}, gpr_wdata, data);
  endtask

  task automatic check_rst_outs(input string tag);
    check({tag, ".we"},       32'(gpr_we), 32'd0);
    check({tag, ".wb_ready"}, 32'(wb_ready), 32'd1);
    check({tag, ".lu_ready"}, 32'(lu_ready), 32'd1);
    check({tag, ".hazard"},   32'(hazard), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    iss_valid = 1'b0; iss_long = 1'b0; iss_rd = 5'd0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;

    // Reset state, with a WB request present that must not write
    @(negedge clk); #1;
    check_rst_outs("reset");

    // WB only
    @(negedge clk); rst = 1'b0; #1;
    check_wr("wb_only", 5'd5, 32'hDEADBEEF);
    check("wb_only.ready", 32'(wb_ready), 32'd1);
    @(negedge clk); wb_rd = 5'd0; #1;
    check("wb_rd0.we", 32'(gpr_we), 32'd0);
    check("wb_rd0.ready", 32'(wb_ready), 32'd1);

    // LU while WB idle
    @(negedge clk); wb_valid = 1'b0; iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7; chk_rs1 = 5'd7; #1;
    check("lu.hazard_before", 32'(hazard), 32'd0);
    @(negedge clk); iss_valid = 1'b0; #1;
    check("lu.hazard_set", 32'(hazard), 32'd1);
    @(negedge clk); lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h12345678; #1;
    check("lu.ready", 32'(lu_ready), 32'd1);
    check("lu.no_bypass", 32'(gpr_we), 32'd0);
    @(negedge clk); lu_valid = 1'b0; #1;
    check_wr("lu.write", 5'd7, 32'h12345678);
    check("lu.hazard_hold", 32'(hazard), 32'd1);
    @(negedge clk); #1;
    check("lu.hazard_clear", 32'(hazard), 32'd0);
    check("lu.idle_we", 32'(gpr_we), 32'd0);

    // Contention / starvation
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd9; chk_rs1 = 5'd9;
    @(negedge clk); iss_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h0000_9999; #1;
    check("starve.hazard9", 32'(hazard), 32'd1);
    check("starve.idle", 32'(gpr_we), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); lu_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0A0_0010; #1;
      check($sformatf("starve.wb_win%0d.ready", i), 32'(wb_ready), 32'd1);
      check_wr($sformatf("starve.wb_win%0d", i), 5'd10, 32'hA0A0_0010);
    end
    @(negedge clk); #1;
    check("starve.force.ready", 32'(wb_ready), 32'd0);
    check_wr("starve.force", 5'd9, 32'h0000_9999);
    @(negedge clk); #1;
    check("starve.resume.ready", 32'(wb_ready), 32'd1);
    check_wr("starve.resume", 5'd10, 32'hA0A0_0010);
    check("starve.hazard9_clear", 32'(hazard), 32'd0);

    // FIFO full while WB writes every cycle
    @(negedge clk); wb_rd = 5'd11; wb_data = 32'h0000_00BB; lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC1C1_C1C1; #1;
    check("full.c0.lu_ready", 32'(lu_ready), 32'd1);
    check_wr("full.c0", 5'd11, 32'h0000_00BB);
    @(negedge clk); lu_rd = 5'd13; lu_data = 32'hC2C2_C2C2; #1;
    check("full.c1.lu_ready", 32'(lu_ready), 32'd1);
    check("full.c1.wb_ready", 32'(wb_ready), 32'd1);
    @(negedge clk); lu_rd = 5'd14; lu_data = 32'hC3C3_C3C3; #1;
    check("full.c2.lu_ready", 32'(lu_ready), 32'd0);
    @(negedge clk); #1;
    check("full.c3.lu_ready", 32'(lu_ready), 32'd0);
    check("full.c3.wb_ready", 32'(wb_ready), 32'd1);
    @(negedge clk); #1;
    check("full.c4.lu_ready", 32'(lu_ready), 32'd0);
    check("full.c4.wb_ready", 32'(wb_ready), 32'd1);
    @(negedge clk); #1;
    check("full.c5.wb_ready", 32'(wb_ready), 32'd0);
    check("full.c5.lu_ready", 32'(lu_ready), 32'd0);
    check_wr("full.c5", 5'd12, 32'hC1C1_C1C1);
    @(negedge clk); #1;
    check("full.c6.lu_ready", 32'(lu_ready), 32'd1);
    check_wr("full.c6", 5'd11, 32'h0000_00BB);
    @(negedge clk); lu_valid = 1'b0; wb_valid = 1'b0; #1;
    check_wr("full.drain0", 5'd13, 32'hC2C2_C2C2);
    @(negedge clk); #1;
    check_wr("full.drain1", 5'd14, 32'hC3C3_C3C3);
    @(negedge clk); #1;
    check("full.empty_we", 32'(gpr_we), 32'd0);

    // Scoreboard race: set and clear of rd 3 on the same edge
    @(negedge clk); iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd3; chk_rs1 = 5'd3;
    @(negedge clk); iss_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h0000_0033; #1;
    check("race.hazard_set", 32'(hazard), 32'd1);
    @(negedge clk); lu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3; #1;
    check_wr("race.write", 5'd3, 32'h0000_0033);
    @(negedge clk); iss_valid = 1'b0; #1;
    check("race.busy_kept", 32'(hazard), 32'd1);
    check("race.idle_we", 32'(gpr_we), 32'd0);

    // Async reset with two FIFO entries and busy = {7,3}
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'h0000_0020;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h0000_003A; #1;
    check_wr("arst.wb", 5'd20, 32'h0000_0020);
    @(negedge clk); iss_valid = 1'b0; lu_rd = 5'd7; lu_data = 32'h0000_007A; chk_rs1 = 5'd3; chk_rs2 = 5'd7; #1;
    check("arst.hazard", 32'(hazard), 32'd1);
    check("arst.lu_ready1", 32'(lu_ready), 32'd1);
    @(negedge clk); lu_valid = 1'b0; chk_rs1 = 5'd0; #1;
    check("arst.full", 32'(lu_ready), 32'd0);
    check("arst.hazard7", 32'(hazard), 32'd1);
    #1 rst = 1'b1; #1;
    check_rst_outs("arst.during");
    @(negedge clk); rst = 1'b0; wb_valid = 1'b0; chk_rs1 = 5'd3; #1;
    check("arst.post0.we", 32'(gpr_we), 32'd0);
    check("arst.post0.hazard", 32'(hazard), 32'd0);
    check("arst.post0.lu_ready", 32'(lu_ready), 32'd1);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); #1;
      check($sformatf("arst.post%0d.we", i), 32'(gpr_we), 32'd0);
    end
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0011; #1;
    check_wr("arst.new_wb", 5'd1, 32'h0000_0011);

    @(negedge clk); wb_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_wport_arbiter.md
Name: gpr_wport_arbiter

Overview:
- Shares the single GPR write port between the in-order pipeline writeback (WB) and a long-latency unit (LU, e.g. mul/div or load return).
- Buffers LU results in a 2-entry FIFO.
- Keeps a 32-bit busy scoreboard of registers with pending LU writes and flags issue hazards.
- Sits between the WB stage/LU and the register file write inputs (we/waddr/wdata).

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose to WB before WB is forced to wait (1..15).
- FIFO_DEPTH, 2, LU result buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wb_valid  in  1  WB stage has a result
- wb_rd  in  5  WB destination
- wb_data  in  32  WB result
- wb_ready  out  1  WB accepted this cycle; 0 = pipeline must hold WB stage
- lu_valid  in  1  LU result offered
- lu_rd  in  5  LU destination
- lu_data  in  32  LU result
- lu_ready  out  1  FIFO can accept (not full)
- iss_valid  in  1  instruction issuing this cycle
- iss_long  in  1  issuing instruction completes through LU
- iss_rd  in  5  issuing instruction destination
- chk_rs1  in  5  decode source 1
- chk_rs2  in  5  decode source 2
- chk_rd  in  5  decode destination (WAW check)
- hazard  out  1  decode must stall
- gpr_we  out  1  register-file write enable
- gpr_waddr  out  5  register-file write address
- gpr_wdata  out  32  register-file write data

Behaviour:
- Reset state: FIFO empty, busy = 0, starve_cnt = 0. While rst is high, gpr_we = 0, wb_ready = 1, lu_ready = 1, hazard = 0.
- Output paths: gpr_* and wb_ready are combinational from the current inputs and state. The write reaches the GPR at the next clk edge, so there is zero added latency for WB. An LU result is written at the earliest 1 cycle after acceptance.
- wb_valid with wb_rd = 0: treated as no request; wb_ready = 1.
- LU enqueue: occurs when lu_valid and lu_ready are both high at clk.
  - lu_ready = !full. lu_valid and its payload must stay stable until accepted.
  - lu_rd = 0 is accepted but not enqueued.
- Grant priority:
  - force = (starve_cnt == STARVE_LIMIT) and FIFO non-empty.
  - If force: grant FIFO head, wb_ready = 0.
  - Else if WB request: grant WB, wb_ready = 1.
  - Else if FIFO non-empty: grant FIFO head.
  - Else gpr_we = 0. Address and data are don't-care but are driven from the WB inputs.
- FIFO pop: occurs at clk when the FIFO head is granted.
- Simultaneous push and pop on a full FIFO:
  - lu_ready is still 0 when full; there is no bypass.
  - Push into an empty FIFO is not written the same cycle; there is no combinational bypass from LU to the GPR.
- starve_cnt:
  - Increments at clk when the FIFO is non-empty and WB is granted.
  - Clears when the FIFO pops or is empty.
  - Saturates at STARVE_LIMIT.
- Scoreboard:
  - Set: busy[iss_rd] is set at clk when iss_valid and iss_long are high and iss_rd != 0.
  - Clear: busy[gpr_waddr] is cleared at clk on a FIFO-sourced write.
  - Same-index set and clear: set wins.
  - WB writes never touch busy.
  - busy[0] is always 0.
- hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], combinational. Index 0 never hazards.
- LU results return in issue order. A given rd is never busy twice, which WAW hazard guarantees.
- Reset mid-operation: FIFO contents are discarded and busy is cleared immediately (async). No write is issued after rst deasserts until a new request arrives.

Test Plan:
- WB only: wb_valid = 1, rd = 5, data = 0xDEADBEEF -> same cycle gpr_we = 1, waddr = 5, wdata = 0xDEADBEEF, wb_ready = 1. Check wb_rd = 0 gives gpr_we = 0.
- LU while WB idle:
  - Issue long op with rd = 7 -> busy[7] set, and hazard = 1 for chk_rs1 = 7.
  - LU returns rd = 7, data = 0x12345678 -> written 1 cycle after acceptance, busy[7] clears, hazard drops the next cycle.
- Contention/starvation:
  - Setup: FIFO holds rd = 9, and wb_valid is held high for 6 cycles.
  - WB wins for 4 cycles; on the 5th cycle, wb_ready = 0 and rd = 9 is written.
  - WB resumes the following cycle with its held data intact.
- FIFO full: two LU entries are enqueued while WB is busy every cycle -> lu_ready = 0. A third lu_valid is held and accepted only after a pop. Order of writes = enqueue order.
- Scoreboard race: issue long op with rd = 3 in the same cycle as the FIFO write of rd = 3 from an earlier op -> busy[3] remains 1.
- Async reset with 2 FIFO entries and busy = 0x0000_0088 -> outputs return to reset values immediately, and no stale write occurs after release.
